serial_adder_sub: RTL and testbench

SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/digit_adder.sv | 34 +++
 rtl/serial_adder_sub.sv | 133 +++++++++++++
 tb/tb_serial_adder_sub.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and per-bit full-adder helper for the serial adder/subtractor.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum} of one full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide combinational ripple adder; c_msb is the carry entering the top cell.
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic       cy;
    logic [1:0] r;

    always_comb begin
        s     = '0;
        r     = '0;
        cy    = ci;
        c_msb = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = cy;
            end
            r    = full_add(a[i], b[i], cy);
            s[i] = r[0];
            cy   = r[1];
        end
        co = cy;
    end

endmodule

// File: rtl/serial_adder_sub.sv
// Digit-serial add/subtract: WIDTH/DIGIT busy cycles, then a one-cycle Done; Start ignored while busy.
// Define SERIAL_ADDER_OVF_EN to enable signed-overflow detection on Overflow.
module serial_adder_sub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_chk_width
        $error("serial_adder_sub: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_chk_digit
        $error("serial_adder_sub: WIDTH must be a multiple of DIGIT");
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       a_q, b_q, sum_q;
    logic                   carry_q;
    logic                   accept, last;
    logic [DIGIT-1:0]       dig_s;
    logic                   dig_co, dig_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    assign last    = (cnt_q == CW'(N - 1));
    assign sum_cat = {dig_s, sum_q};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // B is inverted at capture so the serial datapath only ever adds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= A;
                b_q     <= Sub ? ~B : B;
                sum_q   <= '0;
                carry_q <= Cin;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
                carry_q <= dig_co;
                cnt_q   <= last ? '0 : cnt_q + CW'(1);
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last) begin
            ovf_q <= dig_cmsb ^ dig_co;
        end
    end

    assign Overflow = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = dig_cmsb;
    assign Overflow    = 1'b0;
`endif

    assign Busy  = (state_q == RUN);
    assign Done  = (state_q == DONE);
    assign Sum   = sum_q;
    assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench: an arithmetic reference model checked every cycle plus directed literal checks.
module tb_serial_adder_sub;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       sub = 1'b0;

    logic       busy0, done0, carry0, ovf0;
    logic [7:0] sum0;
    logic       busy1, done1, carry1, ovf1;
    logic [7:0] sum1;

    int tests = 0;
    int fails = 0;

    serial_adder_sub #(.WIDTH(8), .DIGIT(1)) dut0 (
        .CLK(CLK), .RST(RST), .Start(start0), .A(a), .B(b), .Cin(cin), .Sub(sub),
        .Busy(busy0), .Done(done0), .Sum(sum0), .Carry(carry0), .Overflow(ovf0)
    );

    serial_adder_sub #(.WIDTH(8), .DIGIT(4)) dut1 (
        .CLK(CLK), .RST(RST), .Start(start1), .A(a), .B(b), .Cin(cin), .Sub(sub),
        .Busy(busy1), .Done(done1), .Sum(sum1), .Carry(carry1), .Overflow(ovf1)
    );

    always #5 CLK = ~CLK;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nof(input int id);
        return (id == 0) ? 8 : 2;
    endfunction

    // Reference model: result from plain arithmetic, timing from the accept edge.
    int         ka [2];
    logic [7:0] es [2];
    logic       ec [2];
    logic       eo [2];
    int         e;

    initial begin
        logic       st;
        logic [7:0] bx;
        logic [8:0] r;
        logic       xb, xd, act_b, act_d, act_c, act_o;
        logic [7:0] act_s;
        ka[0] = -1000; ka[1] = -1000;
        es[0] = 8'h00; es[1] = 8'h00;
        ec[0] = 1'b0;  ec[1] = 1'b0;
        eo[0] = 1'b0;  eo[1] = 1'b0;
        e = 0;
        forever begin
            @(posedge CLK);
            e++;
            for (int id = 0; id < 2; id++) begin
                st = (id == 0) ? start0 : start1;
                if (RST) begin
                    ka[id] = -1000;
                    es[id] = 8'h00;
                    ec[id] = 1'b0;
                    eo[id] = 1'b0;
                end else if (st && !(ka[id] <= e - 1 && e - 1 <= ka[id] + nof(id) - 1)) begin
                    ka[id] = e;
                    bx     = sub ? ~b : b;
                    r      = {1'b0, a} + {1'b0, bx} + {8'b0, cin};
                    es[id] = r[7:0];
                    ec[id] = r[8];
                    eo[id] = OVF_ON & (a[7] == bx[7]) & (r[7] != a[7]);
                end
            end
            @(negedge CLK);
            for (int id = 0; id < 2; id++) begin
                xb    = (ka[id] <= e) && (e <= ka[id] + nof(id) - 1);
                xd    = (e == ka[id] + nof(id));
                act_b = (id == 0) ? busy0 : busy1;
                act_d = (id == 0) ? done0 : done1;
                act_s = (id == 0) ? sum0 : sum1;
                act_c = (id == 0) ? carry0 : carry1;
                act_o = (id == 0) ? ovf0 : ovf1;
                check($sformatf("model_busy%0d", id), 32'(act_b), 32'(xb));
                check($sformatf("model_done%0d", id), 32'(act_d), 32'(xd));
                if (!xb) begin
                    check($sformatf("model_sum%0d", id), 32'(act_s), 32'(es[id]));
                    check($sformatf("model_carry%0d", id), 32'(act_c), 32'(ec[id]));
                    check($sformatf("model_ovf%0d", id), 32'(act_o), 32'(eo[id]));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the Done cycle.
    task automatic run_op(input int id, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ci, input logic su, input int lat,
                          output logic [7:0] s, output logic c, output logic o);
        int n;
        a = aa; b = bb; cin = ci; sub = su;
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                start0 = 1'b0; start1 = 1'b0;
                a = ~aa; b = ~bb; cin = ~ci; sub = ~su;
                check($sformatf("busy_first%0d", id), 32'((id == 0) ? busy0 : busy1), 32'd1);
            end
        end while (!((id == 0) ? done0 : done1) && n < 40);
        check($sformatf("latency%0d", id), 32'(n), 32'(lat));
        s = (id == 0) ? sum0 : sum1;
        c = (id == 0) ? carry0 : carry1;
        o = (id == 0) ? ovf0 : ovf1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic       c, o;
        int         n, pulses;

        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_sum", 32'(sum0), 32'd0);
        check("rst_carry", 32'(carry0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, 9, s, c, o);
        check("add_0f_01_sum", 32'(s), 32'h10);
        check("add_0f_01_carry", 32'(c), 32'd0);
        // Each following op starts in the Done cycle of the previous one.
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 9, s, c, o);
        check("add_ff_01_sum", 32'(s), 32'h00);
        check("add_ff_01_carry", 32'(c), 32'd1);
        check("add_ff_01_ovf", 32'(o), 32'd0);
        run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 9, s, c, o);
        check("sub_05_07_sum", 32'(s), 32'hFE);
        check("sub_05_07_carry", 32'(c), 32'd0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 9, s, c, o);
        check("add_7f_01_sum", 32'(s), 32'h80);
        check("add_7f_01_ovf", 32'(o), 32'(OVF_ON));
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 9, s, c, o);
        check("sub_80_01_sum", 32'(s), 32'h7F);
        check("sub_80_01_ovf", 32'(o), 32'(OVF_ON));
        repeat (3) @(negedge CLK);

        // Second Start during RUN must be ignored.
        a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start0 = 1'b1;
        @(negedge CLK); start0 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        a = 8'h00; b = 8'h00; start0 = 1'b1;
        @(negedge CLK); start0 = 1'b0;
        n = 4;
        while (!done0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("ignored_start_latency", 32'(n), 32'd9);
        check("ignored_start_sum", 32'(sum0), 32'h10);
        @(negedge CLK);
        check("done_to_idle", 32'(busy0 | done0), 32'd0);
        check("hold_sum", 32'(sum0), 32'h10);
        repeat (2) @(negedge CLK);

        // Reset in the middle of a RUN aborts it.
        a = 8'h33; b = 8'h44; start0 = 1'b1;
        @(negedge CLK); start0 = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_sum", 32'(sum0), 32'd0);
        check("abort_carry", 32'(carry0), 32'd0);
        check("abort_ovf", 32'(ovf0), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done0) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // DIGIT=4 instance.
        run_op(1, 8'hA5, 8'h5B, 1'b0, 1'b0, 3, s, c, o);
        check("d4_add_sum", 32'(s), 32'h00);
        check("d4_add_carry", 32'(c), 32'd1);
        run_op(1, 8'h30, 8'h10, 1'b1, 1'b1, 3, s, c, o);
        check("d4_sub_sum", 32'(s), 32'h20);
        check("d4_sub_carry", 32'(c), 32'd1);
        run_op(1, 8'h70, 8'h10, 1'b0, 1'b0, 3, s, c, o);
        check("d4_ovf_sum", 32'(s), 32'h80);
        check("d4_ovf", 32'(o), 32'(OVF_ON));
        repeat (4) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
